cpu_mc_sequencer: RTL and testbench
===================================

Name: cpu_mc_sequencer

Overview:
Multi-cycle sequencer for the cpu_v3 datapath. It fetches each instruction through a request/valid instruction-memory port and holds it in an instruction register that feeds the combinational control decoder. It then steps the instruction through decode, execute, memory and writeback, gating register-file and data-memory write enables to a single phase. It owns the PC, the retired-instruction counter and the sticky halt/fault status.

Parameters:
ADDR_W, 32, width of PC and of instruction/data addresses
RESET_PC, 0, PC value loaded on reset
FETCH_TIMEOUT, 255, maximum cycles spent waiting for imem_rvalid before fault

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
run  in  1  when 0, no new fetch is issued (holds in IF); in-flight instruction completes
imem_req  out  1  one-cycle fetch request
imem_addr  out  ADDR_W  fetch address, equals pc
imem_rvalid  in  1  fetch data valid; earliest is the cycle after imem_req
imem_rdata  in  32  fetched instruction
instr  out  32  instruction register, drives the decoder
dec_rf_we  in  1  decoder register-write flag
dec_mem_we  in  1  decoder store flag
dec_branch  in  1  decoder branch flag
dec_illegal  in  1  decoder unknown-instruction flag
cmp_true  in  1  datapath branch condition, valid in EX
br_offset  in  ADDR_W  sign-extended byte branch offset, valid in EX
rf_we  out  1  register-file write strobe
dmem_we  out  1  data-memory write request
dmem_ack  in  1  store accepted; may be high in the same cycle as dmem_we
pc  out  ADDR_W  current PC
instret  out  32  retired-instruction count, wraps 0xFFFFFFFF -> 0
halted  out  1  sticky halt
fault  out  2  00 none, 01 illegal instruction, 10 fetch timeout, 11 misaligned branch target

Behaviour:
- Reset values: pc=RESET_PC, instr=0, instret=0, halted=0, fault=00, state=IF, timeout counter=0. imem_req, rf_we and dmem_we are 0 during and after reset.
- Reset has priority over every other event, including mid-store and HALT. An outstanding fetch or store is abandoned; a late rvalid or ack is ignored while in IF.
- All strobe outputs are combinational functions of the registered state only.
- IF: if run=1, imem_req=1 and the next state is IW. If run=0, stay in IF with no request.
- IW: increment the timeout counter each cycle.
  - imem_rvalid=1: latch instr<=imem_rdata, clear the counter, go to DEC.
  - Counter reaches FETCH_TIMEOUT without rvalid: go to HALT with fault=10.
  - rvalid takes precedence on the final cycle.
- DEC: one cycle. Latch dec_* into internal flags.
  - dec_illegal=1: go to HALT with fault=01; pc and instret are unchanged.
  - Otherwise go to EX.
- EX: one cycle.
  - Branch flag set, target = pc + br_offset (mod 2^ADDR_W):
    - cmp_true=1 and target[1:0]!=0: go to HALT with fault=11; pc unchanged.
    - cmp_true=1 and target aligned: pc<=target.
    - cmp_true=0: pc<=pc+4.
    - In both non-fault cases, retire and go to IF.
  - Else if store flag set: go to MEM.
  - Else: go to WB.
- MEM: dmem_we=1, held until a cycle in which dmem_ack=1. In that cycle: pc<=pc+4, retire, go to IF.
- WB: rf_we = latched rf_we flag, for exactly one cycle. pc<=pc+4, retire, go to IF.
- Retire means instret<=instret+1.
- HALT: halted=1 and all strobes are 0. Exited only by rst.
- PC arithmetic wraps modulo 2^ADDR_W.
- Minimum latency with rvalid in the first IW cycle:
  - ALU-op: 5 cycles.
  - Branch: 4 cycles.
  - Store with immediate ack: 5 cycles.
- rf_we and dmem_we are never high in the same cycle. Neither is ever high outside WB or MEM respectively.

Test Plan:
- ADDI x1,x0,5 (0x00500093), rvalid 1 cycle after req, run=1 -> rf_we pulses exactly once, in cycle 5 after reset release; pc 0->4; instret=1.
- BEQ with cmp_true=1, br_offset=-8, pc=0x10 -> no rf_we and no dmem_we; pc=0x08 after 4 cycles. Repeat with br_offset=6 -> halted=1, fault=11, pc stays 0x10.
- SW with dmem_ack delayed 3 cycles -> dmem_we high for exactly 4 cycles; pc advances by 4 only on the ack cycle; instret increments once.
- Fetch returning 0xFFFFFFFF (illegal) -> HALT with fault=01 after DEC. A later run toggle leaves halted=1; rst clears to pc=RESET_PC, fault=00.
- imem_rvalid never asserted, FETCH_TIMEOUT=4 -> halted=1, fault=10, 4 cycles after entering IW. Separately, rvalid exactly on the 4th IW cycle -> no fault.
- run=0 held 10 cycles after reset -> imem_req stays 0. Also: assert rst in MEM with dmem_ack low -> next cycle dmem_we=0, state IF, instret=0.

Source files
------------

// File: rtl/cpu_mc_sequencer.sv
// cpu_mc_sequencer: multi-cycle control sequencer for the cpu_v3 datapath.
// Fetches through a request/valid port into the instruction register, then
// walks each instruction through DEC, EX, MEM and WB. It owns the PC, the
// retired-instruction counter and the sticky halt/fault status.
module cpu_mc_sequencer #(
    parameter int                ADDR_W        = 32,
    parameter logic [ADDR_W-1:0] RESET_PC      = '0,
    parameter int                FETCH_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    input  logic              dec_rf_we,
    input  logic              dec_mem_we,
    input  logic              dec_branch,
    input  logic              dec_illegal,
    input  logic              cmp_true,
    input  logic [ADDR_W-1:0] br_offset,
    output logic              rf_we,
    output logic              dmem_we,
    input  logic              dmem_ack,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       instret,
    output logic              halted,
    output logic [1:0]        fault
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_IW   = 3'd1,
        S_DEC  = 3'd2,
        S_EX   = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5,
        S_HALT = 3'd6
    } state_t;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;
    localparam logic [1:0] FAULT_MISALIGN = 2'b11;

    // Counter is wide enough to hold FETCH_TIMEOUT itself; the halt decision
    // is taken on the cycle whose increment would reach the limit.
    localparam int              CNT_W    = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

    state_t            state;
    logic [CNT_W-1:0]  wait_cnt;
    logic              rf_flag;
    logic              mem_flag;
    logic              br_flag;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] br_target;

    // Sequential PC and wrapped branch target; both wrap modulo 2^ADDR_W.
    assign pc_plus4  = pc + ADDR_W'(4);
    assign br_target = pc + br_offset;

    // Strobes depend on the registered state; reset forces them low so an
    // abandoned fetch or store is never presented while rst is held.
    assign imem_req  = (state == S_IF) && run && !rst;
    assign imem_addr = pc;
    assign rf_we     = (state == S_WB) && rf_flag && !rst;
    assign dmem_we   = (state == S_MEM) && !rst;
    assign halted    = (state == S_HALT);

    // Main sequencer: state, PC, instruction register, retire count and fault.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IF;
            pc       <= RESET_PC;
            instr    <= '0;
            instret  <= '0;
            fault    <= FAULT_NONE;
            wait_cnt <= '0;
            rf_flag  <= 1'b0;
            mem_flag <= 1'b0;
            br_flag  <= 1'b0;
        end else begin
            case (state)
                S_IF: begin
                    if (run) begin
                        state    <= S_IW;
                        wait_cnt <= '0;
                    end
                end

                S_IW: begin
                    if (imem_rvalid) begin
                        instr    <= imem_rdata;
                        wait_cnt <= '0;
                        state    <= S_DEC;
                    end else if (wait_cnt == CNT_LAST) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                        fault    <= FAULT_TIMEOUT;
                        state    <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                S_DEC: begin
                    rf_flag  <= dec_rf_we;
                    mem_flag <= dec_mem_we;
                    br_flag  <= dec_branch;
                    if (dec_illegal) begin
                        fault <= FAULT_ILLEGAL;
                        state <= S_HALT;
                    end else begin
                        state <= S_EX;
                    end
                end

                S_EX: begin
                    if (br_flag) begin
                        if (cmp_true && (br_target[1:0] != 2'b00)) begin
                            fault <= FAULT_MISALIGN;
                            state <= S_HALT;
                        end else begin
                            pc      <= cmp_true ? br_target : pc_plus4;
                            instret <= instret + 32'd1;
                            state   <= S_IF;
                        end
                    end else if (mem_flag) begin
                        state <= S_MEM;
                    end else begin
                        state <= S_WB;
                    end
                end

                S_MEM: begin
                    if (dmem_ack) begin
                        pc      <= pc_plus4;
                        instret <= instret + 32'd1;
                        state   <= S_IF;
                    end
                end

                S_WB: begin
                    pc      <= pc_plus4;
                    instret <= instret + 32'd1;
                    state   <= S_IF;
                end

                S_HALT: begin
                    state <= S_HALT;
                end

                default: begin
                    state <= S_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_mc_sequencer.sv
// tb_cpu_mc_sequencer: directed and randomized instruction stream against a
// transaction-level model of the sequencer (per-instruction latency, strobe
// counts, final PC/instret/fault).
module tb_cpu_mc_sequencer;

    localparam int          TMO   = 4;
    localparam logic [31:0] I_ADD = 32'h0050_0093;
    localparam logic [31:0] I_RR  = 32'h0020_81B3;
    localparam logic [31:0] I_SW  = 32'h0011_2023;
    localparam logic [31:0] I_BEQ = 32'h0000_0063;
    localparam logic [31:0] I_ILL = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        dec_rf_we;
    logic        dec_mem_we;
    logic        dec_branch;
    logic        dec_illegal;
    logic        cmp_true;
    logic [31:0] br_offset;
    logic        rf_we;
    logic        dmem_we;
    logic        dmem_ack;
    logic [31:0] pc;
    logic [31:0] instret;
    logic        halted;
    logic [1:0]  fault;

    int errors = 0;
    int checks = 0;
    int step   = 0;

    logic [31:0] m_pc;
    logic [31:0] m_instret;

    int          o_cycles;
    int          o_rf;
    int          o_rf_cyc;
    int          o_we;
    int          o_both;
    int          o_pc_moved;
    int          o_req_cyc;
    logic [31:0] o_req_addr;
    logic        o_bound;

    always #5 clk = ~clk;

    cpu_mc_sequencer #(
        .ADDR_W       (32),
        .RESET_PC     (32'h0),
        .FETCH_TIMEOUT(TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .dec_rf_we  (dec_rf_we),
        .dec_mem_we (dec_mem_we),
        .dec_branch (dec_branch),
        .dec_illegal(dec_illegal),
        .cmp_true   (cmp_true),
        .br_offset  (br_offset),
        .rf_we      (rf_we),
        .dmem_we    (dmem_we),
        .dmem_ack   (dmem_ack),
        .pc         (pc),
        .instret    (instret),
        .halted     (halted),
        .fault      (fault)
    );

    // Minimal RV32 opcode decoder standing in for the datapath decoder.
    logic [6:0] op;
    assign op          = instr[6:0];
    assign dec_rf_we   = (op == 7'h13) || (op == 7'h33);
    assign dec_mem_we  = (op == 7'h23);
    assign dec_branch  = (op == 7'h63);
    assign dec_illegal = !(dec_rf_we || dec_mem_we || dec_branch);

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s step=%0d observed=0x%08h expected=0x%08h", tag, step, obs, exp);
        end
    endtask

    task automatic apply_reset(input logic run_val);
        rst         = 1'b1;
        run         = run_val;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        dmem_ack    = 1'b0;
        cmp_true    = 1'b0;
        br_offset   = '0;
        repeat (2) @(negedge clk);
        check_output("rst_imem_req", imem_req, 0);
        check_output("rst_rf_we", rf_we, 0);
        check_output("rst_dmem_we", dmem_we, 0);
        rst = 1'b0;
        #1;
        m_pc      = 32'h0;
        m_instret = 32'h0;
        check_output("rst_pc", pc, 32'h0);
        check_output("rst_instr", instr, 32'h0);
        check_output("rst_instret", instret, 32'h0);
        check_output("rst_halted", halted, 0);
        check_output("rst_fault", fault, 0);
    endtask

    // Expected outcome of one instruction from its class and handshake delays.
    task automatic predict(input logic [31:0] word, input int d, input int a, input logic cmp,
                           input logic [31:0] off, output int e_cycles, output int e_rf,
                           output int e_we, output logic e_halt, output logic [1:0] e_fault);
        logic [6:0]  opc;
        logic [31:0] target;
        opc      = word[6:0];
        e_rf     = 0;
        e_we     = 0;
        e_halt   = 1'b0;
        e_fault  = 2'b00;
        e_cycles = 0;
        if (d >= TMO) begin
            e_cycles = 1 + TMO;
            e_halt   = 1'b1;
            e_fault  = 2'b10;
        end else if (opc == 7'h63) begin
            e_cycles = 4 + d;
            target   = m_pc + off;
            if (cmp && (target % 4 != 0)) begin
                e_halt  = 1'b1;
                e_fault = 2'b11;
            end else begin
                m_pc      = cmp ? target : m_pc + 4;
                m_instret = m_instret + 1;
            end
        end else if (opc == 7'h23) begin
            e_cycles  = 5 + d + a;
            e_we      = a + 1;
            m_pc      = m_pc + 4;
            m_instret = m_instret + 1;
        end else if (opc == 7'h13 || opc == 7'h33) begin
            e_cycles  = 5 + d;
            e_rf      = 1;
            m_pc      = m_pc + 4;
            m_instret = m_instret + 1;
        end else begin
            e_cycles = 3 + d;
            e_halt   = 1'b1;
            e_fault  = 2'b01;
        end
    endtask

    // Drive one instruction: answer the fetch d cycles late and the store
    // after a cycles of dmem_we, recording strobe activity until retire/halt.
    task automatic apply_stimulus(input logic [31:0] word, input int d, input int a,
                                  input logic cmp, input logic [31:0] off);
        int          mem_n;
        logic [31:0] start_instret;
        logic [31:0] start_pc;
        start_instret = instret;
        start_pc      = pc;
        o_cycles   = 0;
        o_rf       = 0;
        o_rf_cyc   = 0;
        o_we       = 0;
        o_both     = 0;
        o_pc_moved = 0;
        o_req_cyc  = 0;
        o_req_addr = '0;
        o_bound    = 1'b1;
        mem_n      = 0;
        cmp_true   = cmp;
        br_offset  = off;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (imem_req === 1'b1) begin
                o_req_cyc  = cyc;
                o_req_addr = imem_addr;
            end
            if (rf_we === 1'b1) begin
                o_rf++;
                o_rf_cyc = cyc;
            end
            if (dmem_we === 1'b1) o_we++;
            if (rf_we === 1'b1 && dmem_we === 1'b1) o_both++;
            if (pc !== start_pc) o_pc_moved++;
            imem_rvalid = (o_req_cyc > 0) && (cyc == o_req_cyc + 1 + d);
            imem_rdata  = imem_rvalid ? word : $urandom();
            if (dmem_we === 1'b1) begin
                mem_n++;
                dmem_ack = (mem_n == a + 1);
            end else begin
                dmem_ack = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            if (instret !== start_instret || halted === 1'b1) begin
                o_cycles = cyc;
                o_bound  = 1'b0;
                break;
            end
        end
        imem_rvalid = 1'b0;
        dmem_ack    = 1'b0;
    endtask

    task automatic run_one(input logic [31:0] word, input int d, input int a,
                           input logic cmp, input logic [31:0] off);
        int          e_cycles;
        int          e_rf;
        int          e_we;
        logic        e_halt;
        logic [1:0]  e_fault;
        logic [31:0] pc0;
        step++;
        pc0 = m_pc;
        predict(word, d, a, cmp, off, e_cycles, e_rf, e_we, e_halt, e_fault);
        apply_stimulus(word, d, a, cmp, off);
        check_output("no_hang", o_bound, 0);
        check_output("cycles", o_cycles, e_cycles);
        check_output("rf_pulses", o_rf, e_rf);
        check_output("rf_cycle", o_rf_cyc, (e_rf != 0) ? e_cycles : 0);
        check_output("dmem_we_cycles", o_we, e_we);
        check_output("we_overlap", o_both, 0);
        check_output("fetch_addr", o_req_addr, pc0);
        check_output("pc_held", o_pc_moved, 0);
        check_output("pc", pc, m_pc);
        check_output("instret", instret, m_instret);
        check_output("halted", halted, e_halt);
        check_output("fault", fault, e_fault);
    endtask

    initial begin
        int          sel;
        int          d;
        int          a;
        int          k;
        logic        c;
        logic [31:0] w;
        logic [31:0] off;
        int          seen;

        // run held low: no fetch, stray rvalid ignored in IF
        apply_reset(1'b0);
        for (int i = 0; i < 10; i++) begin
            check_output("idle_req", imem_req, 0);
            imem_rvalid = 1'($urandom_range(0, 1));
            imem_rdata  = $urandom();
            @(negedge clk);
        end
        imem_rvalid = 1'b0;
        check_output("idle_instr", instr, 32'h0);
        check_output("idle_pc", pc, 32'h0);

        // ALU op straight after reset, then walk PC to 0x10
        apply_reset(1'b1);
        run_one(I_ADD, 0, 0, 1'b0, 32'h0);
        repeat (3) run_one(I_ADD, 0, 0, 1'b0, 32'h0);
        check_output("pc_at_10", pc, 32'h10);

        // taken backward branch, then misaligned taken branch from 0x10
        run_one(I_BEQ, 0, 0, 1'b1, 32'hFFFF_FFF8);
        repeat (2) run_one(I_ADD, 0, 0, 1'b0, 32'h0);
        run_one(I_BEQ, 0, 0, 1'b1, 32'h0000_0006);

        // store with ack three cycles late
        apply_reset(1'b1);
        run_one(I_SW, 0, 3, 1'b0, 32'h0);

        // illegal instruction halts; run toggling cannot leave HALT
        run_one(I_ILL, 0, 0, 1'b0, 32'h0);
        run = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_output("halt_sticky_run0", halted, 1);
            check_output("halt_no_req0", imem_req, 0);
        end
        run = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_output("halt_sticky_run1", halted, 1);
            check_output("halt_no_req1", imem_req, 0);
        end
        apply_reset(1'b1);

        // fetch timeout, then rvalid exactly on the last allowed IW cycle
        run_one(I_ADD, TMO, 0, 1'b0, 32'h0);
        apply_reset(1'b1);
        run_one(I_ADD, TMO - 1, 0, 1'b0, 32'h0);

        // randomized stream
        for (int n = 0; n < 40; n++) begin
            sel = int'($urandom_range(0, 3));
            d   = int'($urandom_range(0, 2));
            a   = int'($urandom_range(0, 3));
            c   = 1'($urandom_range(0, 1));
            k   = int'($urandom_range(0, 64)) - 32;
            off = 32'(k * 4);
            if (!c) off = off + 32'($urandom_range(0, 3));
            case (sel)
                0:       w = I_ADD;
                1:       w = I_RR;
                2:       w = I_SW;
                default: w = I_BEQ;
            endcase
            run_one(w, d, a, c, off);
        end

        // reset while a store is waiting for ack
        apply_reset(1'b1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (dmem_we === 1'b1) begin
                seen = 1;
                break;
            end
            imem_rvalid = (i == 1);
            imem_rdata  = I_SW;
            dmem_ack    = 1'b0;
            @(negedge clk);
        end
        imem_rvalid = 1'b0;
        check_output("mem_reached", seen, 1);
        rst = 1'b1;
        @(negedge clk);
        check_output("mem_rst_we", dmem_we, 0);
        check_output("mem_rst_instret", instret, 32'h0);
        check_output("mem_rst_pc", pc, 32'h0);
        rst = 1'b0;
        #1;
        check_output("mem_rst_if_req", imem_req, 1);
        @(negedge clk);
        check_output("mem_rst_we_after", dmem_we, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
